// File: rtl/mips_pkg.sv
// mips_pkg: shared GPR addressing and byte-lane geometry for the pipeline.
//   REG_ADDR_W : GPR address width
//   NUM_LANES  : byte lanes per GPR
//   LANE_W     : bits per lane
//   REG_ZERO   : hardwired-zero register index
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_LANES = 4;
    localparam int LANE_W = 8;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_byte_merge.sv
// wb_byte_merge: per-lane select between new source data and the old register value.
//   src    in  : new data
//   old    in  : current register contents
//   en     in  : lane enables, bit i selects src for lane i
//   merged out : combined word
module wb_byte_merge
    import mips_pkg::*;
(
    input  logic [NUM_LANES*LANE_W-1:0] src,
    input  logic [NUM_LANES*LANE_W-1:0] old,
    input  logic [NUM_LANES-1:0]        en,
    output logic [NUM_LANES*LANE_W-1:0] merged
);
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign merged[i*LANE_W +: LANE_W] = en[i] ? src[i*LANE_W +: LANE_W] : old[i*LANE_W +: LANE_W];
    end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB write-back stage committing merged results into a 32x32 GPR file.
//   clk, Reset_n (sync, active-low)
//   ALUShift_out_in, Data_in, MemtoReg_in : write source and its select
//   Rd_write_by_en_in, Overflow_in, RegWr_in, Rd_in : commit control
//   Rs_addr/Rs_data, Rt_addr/Rt_data : combinational decode read ports
//   Wb_data, Wb_valid : value being committed this cycle and commit strobe
//   Wb_count : committed writes since reset, wrapping
// Optional macro WB_BYPASS_EN: read ports return the committing value in the same cycle.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  Reset_n,
    input  logic [DATA_W-1:0]     ALUShift_out_in,
    input  logic [DATA_W-1:0]     Data_in,
    input  logic [NUM_LANES-1:0]  Rd_write_by_en_in,
    input  logic                  Overflow_in,
    input  logic                  RegWr_in,
    input  logic                  MemtoReg_in,
    input  logic [REG_ADDR_W-1:0] Rd_in,
    input  logic [REG_ADDR_W-1:0] Rs_addr,
    input  logic [REG_ADDR_W-1:0] Rt_addr,
    output logic [DATA_W-1:0]     Rs_data,
    output logic [DATA_W-1:0]     Rt_data,
    output logic [DATA_W-1:0]     Wb_data,
    output logic                  Wb_valid,
    output logic [CNT_W-1:0]      Wb_count
);
    logic [DATA_W-1:0] gpr_q [NREGS];
    logic [DATA_W-1:0] gpr_d [NREGS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] src, merged, rs_arr, rt_arr;
    logic              commit;

    assign src    = MemtoReg_in ? Data_in : ALUShift_out_in;
    assign commit = Reset_n & RegWr_in & ~Overflow_in & (Rd_in != REG_ZERO) & (|Rd_write_by_en_in);

    wb_byte_merge u_merge (
        .src    (src),
        .old    (gpr_q[Rd_in]),
        .en     (Rd_write_by_en_in),
        .merged (merged)
    );

    always_comb begin
        gpr_d = gpr_q;
        if (commit) gpr_d[Rd_in] = merged;
        cnt_d = commit ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            gpr_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            gpr_q <= gpr_d;
            cnt_q <= cnt_d;
        end
    end

    // r0 is forced to zero on read so it holds even before the first reset edge
    assign rs_arr = (Rs_addr == REG_ZERO) ? '0 : gpr_q[Rs_addr];
    assign rt_arr = (Rt_addr == REG_ZERO) ? '0 : gpr_q[Rt_addr];

`ifdef WB_BYPASS_EN
    assign Rs_data = (commit && Rs_addr == Rd_in) ? merged : rs_arr;
    assign Rt_data = (commit && Rt_addr == Rd_in) ? merged : rt_arr;
`else
    assign Rs_data = rs_arr;
    assign Rt_data = rt_arr;
`endif

    assign Wb_data  = merged;
    assign Wb_valid = commit;
    assign Wb_count = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile against an independent GPR model.
module tb_wb_regfile;
    logic        clk = 0;
    logic        Reset_n;
    logic [31:0] ALUShift_out_in, Data_in;
    logic [3:0]  Rd_write_by_en_in;
    logic        Overflow_in, RegWr_in, MemtoReg_in;
    logic [4:0]  Rd_in, Rs_addr, Rt_addr;
    logic [31:0] Rs_data, Rt_data, Wb_data, Wb_count;
    logic        Wb_valid;

    wb_regfile dut (
        .clk               (clk),
        .Reset_n           (Reset_n),
        .ALUShift_out_in   (ALUShift_out_in),
        .Data_in           (Data_in),
        .Rd_write_by_en_in (Rd_write_by_en_in),
        .Overflow_in       (Overflow_in),
        .RegWr_in          (RegWr_in),
        .MemtoReg_in       (MemtoReg_in),
        .Rd_in             (Rd_in),
        .Rs_addr           (Rs_addr),
        .Rt_addr           (Rt_addr),
        .Rs_data           (Rs_data),
        .Rt_data           (Rt_data),
        .Wb_data           (Wb_data),
        .Wb_valid          (Wb_valid),
        .Wb_count          (Wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_gpr [32];
    logic [31:0] ref_cnt;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    function automatic logic [31:0] read_exp(input logic [4:0] a, input bit com,
                                             input logic [4:0] rd, input logic [31:0] mrg);
        logic [31:0] v;
        v = (a == 0) ? 32'd0 : ref_gpr[a];
`ifdef WB_BYPASS_EN
        if (com && a == rd) v = mrg;
`endif
        return v;
    endfunction

    task automatic cycle(input bit rn, input bit rw, input bit m2r, input bit ovf,
                         input logic [31:0] alu, input logic [31:0] dat, input logic [3:0] en,
                         input logic [4:0] rd, input logic [4:0] rsa, input logic [4:0] rta,
                         input bit chk);
        logic [31:0] src, mrg;
        bit          com;
        @(negedge clk);
        Reset_n = rn; RegWr_in = rw; MemtoReg_in = m2r; Overflow_in = ovf;
        ALUShift_out_in = alu; Data_in = dat; Rd_write_by_en_in = en;
        Rd_in = rd; Rs_addr = rsa; Rt_addr = rta;
        #1;
        src = m2r ? dat : alu;
        for (int i = 0; i < 4; i++)
            mrg[i*8 +: 8] = en[i] ? src[i*8 +: 8] : ref_gpr[rd][i*8 +: 8];
        com = rn && rw && !ovf && rd != 0 && en != 0;
        if (chk) begin
            push("wb_valid", {31'd0, com});
            push("wb_data", mrg);
            push("rs_data", read_exp(rsa, com, rd, mrg));
            push("rt_data", read_exp(rta, com, rd, mrg));
            pop_cmp({31'd0, Wb_valid});
            pop_cmp(Wb_data);
            pop_cmp(Rs_data);
            pop_cmp(Rt_data);
        end
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < 32; i++) ref_gpr[i] = 32'd0;
            ref_cnt = 32'd0;
        end else if (com) begin
            ref_gpr[rd] = mrg;
            ref_cnt = ref_cnt + 32'd1;
        end
        #1;
        push("wb_count", ref_cnt);
        pop_cmp(Wb_count);
    endtask

    task automatic rd_pair(input logic [4:0] a, input logic [4:0] b);
        cycle(1, 0, 0, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'hF, a, a, b, 1);
    endtask

    initial begin
        Reset_n = 0; RegWr_in = 0; MemtoReg_in = 0; Overflow_in = 0;
        ALUShift_out_in = 0; Data_in = 0; Rd_write_by_en_in = 0;
        Rd_in = 0; Rs_addr = 0; Rt_addr = 0;
        for (int i = 0; i < 32; i++) ref_gpr[i] = 32'd0;
        ref_cnt = 32'd0;

        cycle(0, 1, 0, 0, 32'h12345678, 0, 4'hF, 5'd4, 5'd4, 5'd1, 0);
        cycle(0, 1, 0, 0, 32'h12345678, 0, 4'hF, 5'd4, 5'd4, 5'd1, 1);
        for (int i = 0; i < 16; i++) rd_pair(5'(i), 5'(31 - i));

        cycle(1, 1, 0, 0, 32'hDEADBEEF, 0, 4'hF, 5'd5, 5'd1, 5'd2, 1);
        rd_pair(5'd5, 5'd0);
        cycle(1, 1, 1, 0, 32'hFFFFFFFF, 32'h000012AB, 4'b0011, 5'd5, 5'd3, 5'd4, 1);
        rd_pair(5'd5, 5'd5);

        cycle(1, 1, 0, 1, 32'hCAFEF00D, 0, 4'hF, 5'd7, 5'd7, 5'd5, 1);
        cycle(1, 1, 0, 0, 32'hFFFFFFFF, 0, 4'hF, 5'd0, 5'd0, 5'd7, 1);
        rd_pair(5'd0, 5'd7);
        cycle(1, 1, 0, 0, 32'h77777777, 0, 4'h0, 5'd5, 5'd5, 5'd5, 1);
        rd_pair(5'd5, 5'd5);

        cycle(1, 1, 0, 0, 32'h00000011, 0, 4'hF, 5'd9, 5'd1, 5'd2, 1);
        cycle(1, 1, 0, 0, 32'h00000055, 0, 4'hF, 5'd9, 5'd9, 5'd9, 1);
        rd_pair(5'd9, 5'd9);
        cycle(1, 1, 1, 0, 0, 32'hABCD0000, 4'b1100, 5'd9, 5'd9, 5'd9, 1);
        rd_pair(5'd9, 5'd9);

        for (int n = 0; n < 200; n++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 31));
            cycle($urandom_range(0, 24) != 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 7) == 0, $urandom, $urandom, 4'($urandom),
                  rd, ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 1);
        end

        cycle(1, 1, 0, 0, 32'h33333333, 0, 4'hF, 5'd3, 5'd3, 5'd1, 1);
        cycle(0, 1, 0, 0, 32'h44444444, 0, 4'hF, 5'd3, 5'd3, 5'd1, 1);
        rd_pair(5'd3, 5'd9);
        cycle(1, 1, 0, 0, 32'h0000BEEF, 0, 4'hF, 5'd3, 5'd3, 5'd1, 1);
        rd_pair(5'd3, 5'd3);

        if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
